// File: rtl/sevenseg_pkg.sv
// Shared scan-state type and digit-select level helper for seven-segment display users.
// Latency: none, types and a pure function only.
// Backpressure: not applicable.
package sevenseg_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

    // Map a logical "digit enabled" bit onto the pin level the display expects.
    function automatic logic sel_level(input logic enable, input logic active_low);
        return enable ^ active_low;
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot counter and digit index for the display scan, with frame-end and show-phase strobes.
// Latency: strobes are decoded from the current counter/index registers.
// Backpressure: none, free-running from reset.
module sevenseg_scan_timer
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
    output logic                          frame_end_o,
    output logic                          show_o
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] C_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    scan_state_e   state_q, state_d;
    logic          slot_end;

    assign slot_end    = (cnt_q == C_LAST);
    assign frame_end_o = slot_end && (idx_q == I_LAST);
    assign show_o      = (state_q == S_SHOW);
    assign idx_o       = idx_q;

    // Advance the slot counter; step the digit index on slot wrap; derive phase from the next count.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
        end
        state_d = (cnt_d < C_BLANK) ? S_BLANK : S_SHOW;
    end

    // Counter, index and phase registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: one digit per slot, blank gap first, value swapped at frame end.
// Latency: outputs registered one cycle after the scan state; accepted value shown from the next frame.
// Backpressure: out_ready low while a value waits in shadow; SEVENSEG_SCAN_LZB_EN adds leading-zero blanking.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic [NUM_DIGITS*4-1:0] in_value,
    input  logic                    in_valid,
    output logic                    out_ready,
    output logic [3:0]              out_digit,
    output logic [NUM_DIGITS-1:0]   out_sel
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE =
        {NUM_DIGITS{sel_level(1'b0, SEL_ACTIVE_LOW != 0)}};

    logic [IW-1:0] idx;
    logic          frame_end;
    logic          show;

    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0] display_q, display_d;
    logic                       pending_q, pending_d;
    logic [NUM_DIGITS-1:0]      sel_q, sel_d;
    logic [3:0]                 digit_q, digit_d;
    logic                       lit;

    sevenseg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk_i      (in_clk),
        .rst_i      (in_rst),
        .idx_o      (idx),
        .frame_end_o(frame_end),
        .show_o     (show)
    );

    assign out_ready = !pending_q;
    assign out_sel   = sel_q;
    assign out_digit = digit_q;

`ifdef SEVENSEG_SCAN_LZB_EN
    logic upper_zero;

    // True when the current digit and every more-significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= idx) && (display_q[i] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign lit = show && !((idx != '0) && upper_zero);
`else
    assign lit = show;
`endif

    // Capture a new value when idle; hand it to the display only on a frame boundary.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (in_valid && !pending_q) begin
            shadow_d  = in_value;
            pending_d = 1'b1;
        end else if (frame_end && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Select and nibble for the slot; the nibble holds through the blank gap.
    always_comb begin
        sel_d   = SEL_IDLE;
        digit_d = digit_q;
        if (show) begin
            digit_d = display_q[idx];
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sel_d[i] = sel_level(lit && (idx == IW'(i)), SEL_ACTIVE_LOW != 0);
            end
        end
    end

    // Value registers and registered display outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            shadow_q  <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
            sel_q     <= SEL_IDLE;
            digit_q   <= 4'h0;
        end else begin
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            digit_q   <= digit_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, active-high and active-low copies.
// Latency: cycle model pushes expected outputs each edge; scenario tasks pop and compare 1ns later.
// Backpressure: source holds in_valid/in_value until the model and DUT both show ready.
module tb_sevenseg_scan;

    localparam int ND = 4;
    localparam int CD = 8;
    localparam int BC = 2;

    logic        in_clk   = 1'b0;
    logic        in_rst   = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_value = 16'h0;
    logic        out_ready, ready_al;
    logic [3:0]  out_digit, digit_al;
    logic [3:0]  out_sel, sel_al;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] dig;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];

    sevenseg_scan #(
        .NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .SEL_ACTIVE_LOW(0)
    ) u_dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_value(in_value), .in_valid(in_valid),
        .out_ready(out_ready), .out_digit(out_digit), .out_sel(out_sel)
    );

    sevenseg_scan #(
        .NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .SEL_ACTIVE_LOW(1)
    ) u_dut_al (
        .in_clk(in_clk), .in_rst(in_rst), .in_value(in_value), .in_valid(in_valid),
        .out_ready(ready_al), .out_digit(digit_al), .out_sel(sel_al)
    );

    always #5 in_clk = ~in_clk;

    // Expected active-high select for slot s at phase ph of a frame showing v.
    function automatic logic [3:0] f_sel(input logic [15:0] v, input int s, input int ph);
        if (ph < BC) return 4'b0000;
`ifdef SEVENSEG_SCAN_LZB_EN
        if (s > 0 && (v >> (4 * s)) == 16'h0) return 4'b0000;
`endif
        return 4'b0001 << s;
    endfunction

    function automatic logic [3:0] f_nib(input logic [15:0] v, input int s);
        return v[4*s +: 4];
    endfunction

    // Cycle model of the scanner, stepped on each clock edge; pushes what the DUT should show next.
    int         m_c, m_idx;
    logic [3:0] m_disp [ND];
    logic [15:0] m_shadow;
    logic       m_pend, m_lit, m_bnd;
    logic [3:0] m_sel, m_dig;

    initial begin
        forever begin
            @(posedge in_clk or posedge in_rst);
            if (in_rst) begin
                m_c = 0; m_idx = 0; m_shadow = 16'h0; m_pend = 1'b0;
                m_sel = 4'h0; m_dig = 4'h0;
                for (int j = 0; j < ND; j++) m_disp[j] = 4'h0;
                sb_q.delete();
            end else begin
                if (m_c >= BC) begin
                    m_lit = 1'b1;
`ifdef SEVENSEG_SCAN_LZB_EN
                    if (m_idx > 0) begin
                        m_lit = 1'b0;
                        for (int j = m_idx; j < ND; j++) if (m_disp[j] != 4'h0) m_lit = 1'b1;
                    end
`endif
                    m_sel = m_lit ? 4'(1 << m_idx) : 4'b0000;
                    m_dig = m_disp[m_idx];
                end else begin
                    m_sel = 4'b0000;
                end
                m_bnd = (m_c == CD - 1) && (m_idx == ND - 1);
                if (in_valid && !m_pend) begin
                    m_shadow = in_value;
                    m_pend   = 1'b1;
                end else if (m_bnd && m_pend) begin
                    for (int j = 0; j < ND; j++) m_disp[j] = m_shadow[4*j +: 4];
                    m_pend = 1'b0;
                end
                if (m_c == CD - 1) begin
                    m_c   = 0;
                    m_idx = (m_idx + 1) % ND;
                end else begin
                    m_c++;
                end
                sb_q.push_back('{sel: m_sel, dig: m_dig, rdy: !m_pend});
            end
        end
    end

    task automatic test_reset();
        exp_t e;
        logic [3:0] es;
        in_rst = 1'b1;
        #1;
        checks++;
        if (out_sel !== 4'b0000 || out_digit !== 4'h0 || out_ready !== 1'b1 || sel_al !== 4'b1111) begin
            errors++;
            $display("FAIL reset_async: sel=%b dig=%h rdy=%b sel_al=%b, expected 0000 0 1 1111",
                     out_sel, out_digit, out_ready, sel_al);
        end
        @(negedge in_clk);
        in_rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge in_clk); #1;
            if (sb_q.size() == 0) begin
                checks++; errors++; $display("FAIL reset_sb: scoreboard empty at k=%0d", k);
            end else begin
                e = sb_q.pop_front(); checks++;
                if (out_sel !== e.sel || out_digit !== e.dig || out_ready !== e.rdy ||
                    sel_al !== ~e.sel || digit_al !== e.dig || ready_al !== e.rdy) begin
                    errors++;
                    $display("FAIL reset_model k=%0d: sel=%b dig=%h rdy=%b sel_al=%b, expected sel=%b dig=%h rdy=%b",
                             k, out_sel, out_digit, out_ready, sel_al, e.sel, e.dig, e.rdy);
                end
            end
            es = f_sel(16'h0, (k - 1) / CD, (k - 1) % CD);
            checks++;
            if (out_sel !== es || out_digit !== 4'h0) begin
                errors++;
                $display("FAIL reset_scan k=%0d: sel=%b dig=%h, expected sel=%b dig=0", k, out_sel, out_digit, es);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        int n;
        logic [3:0] es;
        in_value = 16'h1234;
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_ready !== 1'b0) begin
            errors++; $display("FAIL load_ready_fall: out_ready=%b, expected 0", out_ready);
        end
        n = 0;
        do begin
            if (n > 0) begin @(posedge in_clk); #1; end
            if (sb_q.size() == 0) begin
                checks++; errors++; $display("FAIL load_sb: scoreboard empty");
            end else begin
                e = sb_q.pop_front(); checks++;
                if (out_sel !== e.sel || out_digit !== e.dig || out_ready !== e.rdy ||
                    sel_al !== ~e.sel || digit_al !== e.dig || ready_al !== e.rdy) begin
                    errors++;
                    $display("FAIL load_model n=%0d: sel=%b dig=%h rdy=%b sel_al=%b, expected sel=%b dig=%h rdy=%b",
                             n, out_sel, out_digit, out_ready, sel_al, e.sel, e.dig, e.rdy);
                end
            end
            n++;
        end while (out_ready !== 1'b1 && n < 40);
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL load_ready_rise: out_ready=%b after %0d cycles, expected 1", out_ready, n);
        end
        for (int k = 1; k <= 32; k++) begin
            @(posedge in_clk); #1;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            es = f_sel(16'h1234, (k - 1) / CD, (k - 1) % CD);
            checks++;
            if (out_sel !== es || (es != 4'b0 && out_digit !== f_nib(16'h1234, (k - 1) / CD))) begin
                errors++;
                $display("FAIL load_frame k=%0d: sel=%b dig=%h, expected sel=%b dig=%h",
                         k, out_sel, out_digit, es, f_nib(16'h1234, (k - 1) / CD));
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        logic [15:0] v;
        logic [3:0] es;
        in_value = 16'hABCD;
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_value = 16'h5678;
        n = 0;
        do begin
            if (n > 0) begin @(posedge in_clk); #1; end
            if (sb_q.size() == 0) begin
                checks++; errors++; $display("FAIL b2b_sb: scoreboard empty");
            end else begin
                e = sb_q.pop_front(); checks++;
                if (out_sel !== e.sel || out_digit !== e.dig || out_ready !== e.rdy ||
                    sel_al !== ~e.sel || digit_al !== e.dig || ready_al !== e.rdy) begin
                    errors++;
                    $display("FAIL b2b_model n=%0d: sel=%b dig=%h rdy=%b sel_al=%b, expected sel=%b dig=%h rdy=%b",
                             n, out_sel, out_digit, out_ready, sel_al, e.sel, e.dig, e.rdy);
                end
            end
            n++;
        end while (out_ready !== 1'b1 && n < 40);
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_rise: out_ready=%b after %0d cycles, expected 1", out_ready, n);
        end
        for (int k = 1; k <= 64; k++) begin
            @(posedge in_clk); #1;
            if (k == 1) in_valid = 1'b0;
            if (sb_q.size() == 0) begin
                checks++; errors++; $display("FAIL b2b_sb: scoreboard empty at k=%0d", k);
            end else begin
                e = sb_q.pop_front(); checks++;
                if (out_sel !== e.sel || out_digit !== e.dig || out_ready !== e.rdy ||
                    sel_al !== ~e.sel || digit_al !== e.dig || ready_al !== e.rdy) begin
                    errors++;
                    $display("FAIL b2b_model k=%0d: sel=%b dig=%h rdy=%b sel_al=%b, expected sel=%b dig=%h rdy=%b",
                             k, out_sel, out_digit, out_ready, sel_al, e.sel, e.dig, e.rdy);
                end
            end
            v  = (k <= 32) ? 16'hABCD : 16'h5678;
            es = f_sel(v, ((k - 1) / CD) % ND, (k - 1) % CD);
            checks++;
            if (out_sel !== es || (es != 4'b0 && out_digit !== f_nib(v, ((k - 1) / CD) % ND)) ||
                (k == 1 && out_ready !== 1'b0) || (k == 32 && out_ready !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_frame k=%0d: sel=%b dig=%h rdy=%b, expected sel=%b dig=%h",
                         k, out_sel, out_digit, out_ready, es, f_nib(v, ((k - 1) / CD) % ND));
            end
        end
    endtask

    task automatic test_active_low();
        int n;
        logic [3:0] es;
        in_value = 16'h00F0;
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (ready_al !== 1'b1 && n < 40) begin
            @(posedge in_clk); #1;
            n++;
        end
        checks++;
        if (ready_al !== 1'b1) begin
            errors++; $display("FAIL al_ready_rise: ready=%b after %0d cycles, expected 1", ready_al, n);
        end
        sb_q.delete();
        for (int k = 1; k <= 32; k++) begin
            @(posedge in_clk); #1;
            es = ~f_sel(16'h00F0, (k - 1) / CD, (k - 1) % CD);
            checks++;
            if (sel_al !== es || (es != 4'b1111 && digit_al !== f_nib(16'h00F0, (k - 1) / CD))) begin
                errors++;
                $display("FAIL al_frame k=%0d: sel=%b dig=%h, expected sel=%b dig=%h",
                         k, sel_al, digit_al, es, f_nib(16'h00F0, (k - 1) / CD));
            end
        end
        sb_q.delete();
    endtask

    task automatic test_lzb();
        int n;
        logic [3:0] es;
        in_value = 16'h0070;
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_ready !== 1'b1 && n < 40) begin
            @(posedge in_clk); #1;
            n++;
        end
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL lzb_ready_rise: out_ready=%b after %0d cycles, expected 1", out_ready, n);
        end
        sb_q.delete();
        for (int k = 1; k <= 32; k++) begin
            @(posedge in_clk); #1;
            es = f_sel(16'h0070, (k - 1) / CD, (k - 1) % CD);
            checks++;
            if (out_sel !== es || (es != 4'b0 && out_digit !== f_nib(16'h0070, (k - 1) / CD))) begin
                errors++;
                $display("FAIL lzb_frame k=%0d: sel=%b dig=%h, expected sel=%b dig=%h",
                         k, out_sel, out_digit, es, f_nib(16'h0070, (k - 1) / CD));
            end
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        logic [3:0] es;
        in_value = 16'h1234;
        in_valid = 1'b1;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_ready !== 1'b1 && n < 40) begin
            @(posedge in_clk); #1;
            n++;
        end
        checks++;
        if (out_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready_rise: out_ready=%b after %0d cycles, expected 1", out_ready, n);
        end
        sb_q.delete();
        in_value = 16'hBEEF;
        in_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge in_clk); #1;
            in_valid = 1'b0;
            if (sb_q.size() == 0) begin
                checks++; errors++; $display("FAIL rmid_sb: scoreboard empty at k=%0d", k);
            end else begin
                e = sb_q.pop_front(); checks++;
                if (out_sel !== e.sel || out_digit !== e.dig || out_ready !== e.rdy ||
                    sel_al !== ~e.sel || digit_al !== e.dig || ready_al !== e.rdy) begin
                    errors++;
                    $display("FAIL rmid_model k=%0d: sel=%b dig=%h rdy=%b sel_al=%b, expected sel=%b dig=%h rdy=%b",
                             k, out_sel, out_digit, out_ready, sel_al, e.sel, e.dig, e.rdy);
                end
            end
        end
        checks++;
        if (out_sel !== 4'b0100 || out_digit !== 4'h2 || out_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pre: sel=%b dig=%h rdy=%b, expected 0100 2 0", out_sel, out_digit, out_ready);
        end
        #2;
        in_rst = 1'b1;
        #1;
        checks++;
        if (out_sel !== 4'b0000 || out_digit !== 4'h0 || out_ready !== 1'b1 ||
            sel_al !== 4'b1111 || digit_al !== 4'h0 || ready_al !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async: sel=%b dig=%h rdy=%b sel_al=%b, expected 0000 0 1 1111",
                     out_sel, out_digit, out_ready, sel_al);
        end
        @(negedge in_clk);
        in_rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge in_clk); #1;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            es = f_sel(16'h0, ((k - 1) / CD) % ND, (k - 1) % CD);
            checks++;
            if (out_sel !== es || (es != 4'b0 && out_digit !== 4'h0) || out_ready !== 1'b1) begin
                errors++;
                $display("FAIL rmid_restart k=%0d: sel=%b dig=%h rdy=%b, expected sel=%b dig=0 rdy=1",
                         k, out_sel, out_digit, out_ready, es);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load();
        test_back_to_back();
        test_active_low();
        test_lzb();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete within 100000 time units");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexed scanner for a multi-digit common-segment seven-segment display.
- Accepts a packed hex value through a valid/ready handshake and cycles through the digits one at a time.
- Drives the 4-bit nibble consumed by the sevenseg decoder, plus a one-hot digit-select bus.
- Inserts a short blanking gap between digits to suppress ghosting; new values take effect only at frame boundaries, so no tearing.

Parameters:
NUM_DIGITS, 4, number of display digits (>=2)
CLK_DIV, 1000, clock cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 2, cycles at start of each slot with all selects inactive (>=1)
SEL_ACTIVE_LOW, 0, 1 = digit selects active-low

Ports:
in_clk  input  1  system clock
in_rst  input  1  reset; asynchronous, active-high
in_value  input  NUM_DIGITS*4  packed hex digits; digit i = in_value[4i+3:4i], digit 0 least significant
in_valid  input  1  in_value valid
out_ready  output  1  block can accept a value
out_digit  output  4  current nibble, to the sevenseg decoder
out_sel  output  NUM_DIGITS  digit select; bit i enables digit i

Behaviour:
- Reset:
  - Applied asynchronously; all registers clear immediately.
  - Reset values: slot counter 0, digit index 0, state S_BLANK, display register 0, shadow register 0, pending 0.
  - Outputs: out_digit 0, out_sel all inactive (0 or all-ones per SEL_ACTIVE_LOW), out_ready 1.
- Slot timing:
  - Counter c runs 0..CLK_DIV-1.
  - c < BLANK_CYCLES: state S_BLANK. Otherwise: state S_SHOW.
  - At c == CLK_DIV-1: c wraps to 0 and the index increments; NUM_DIGITS-1 wraps to 0.
  - Frame boundary = the cycle where the index wraps to 0.
- Outputs:
  - Registered, one cycle after the (c, index) state that produces them.
  - In S_SHOW: out_sel asserts only bit [index], and out_digit = display[index].
  - In S_BLANK: out_sel fully inactive, and out_digit holds its previous value.
- Handshake:
  - out_ready = !pending.
  - in_valid && out_ready: in_value is latched into the shadow register and pending is set. out_ready falls on the next cycle.
  - in_valid while out_ready is low: ignored. The source holds the value.
- Transfer:
  - At a frame boundary with pending = 1: display <= shadow and pending clears. out_ready rises on the next cycle.
  - Digit 0 of the new frame shows the new value.
- Simultaneous events:
  - Handshake on a frame-boundary cycle with pending = 0: the value is captured into shadow but not transferred. It is shown from the following frame.
- Arithmetic:
  - Counter width is $clog2(CLK_DIV); index width is $clog2(NUM_DIGITS).
  - No wider intermediates.

Optional Feature:
- Macro: SEVENSEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: during S_SHOW, digit i > 0 keeps out_sel inactive if display nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. Slot timing is unchanged.
- Undefined: every digit is lit in its S_SHOW phase.

Decomposition:
- Package sevenseg_pkg:
  - typedef enum for scan state {S_BLANK, S_SHOW}.
  - Function for the select-level encoding (active-high/active-low).
  - Shared with sevenseg users.
- Sub-module sevenseg_scan_timer:
  - Slot counter plus digit index, with frame-boundary and show-phase strobes.
- Top module holds the handshake, shadow/display registers, the output registers and the LZB logic.

Test Plan:
(All with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, SEL_ACTIVE_LOW=0 unless stated.)
1. Reset: assert in_rst mid-cycle -> out_sel=0000, out_digit=0, out_ready=1 without waiting for a clock edge. Release -> first S_SHOW output, sel=0001 with digit 0, appears at cycle 3.
2. Load 0x1234 with a single valid pulse:
   - out_ready low until the next frame boundary.
   - Then per slot: 2 cycles sel=0000, then 6 cycles of sel=0001/digit 4, 0010/3, 0100/2, 1000/1.
3. Back-pressure: valid 0xABCD accepted, then 0x5678 held valid ->
   - Ready stays low until the boundary.
   - One full frame shows D,C,B,A; 0x5678 is accepted the cycle after ready rises and is shown the frame after.
4. SEL_ACTIVE_LOW=1, value 0x00F0 -> sel sequence 1110, 1101, 1011, 0111 with digits 0, F, 0, 0; blank gaps are 1111.
5. SEVENSEG_SCAN_LZB_EN defined, value 0x0070:
   - Slots 3 and 2 keep sel=0000 throughout.
   - Slot 1 shows 7; slot 0 shows 0.
   - Macro undefined -> all four slots lit.
6. Reset during S_SHOW of slot 2 with pending=1:
   - Out_sel goes inactive immediately; display and pending cleared; out_ready=1.
   - Scan restarts at slot 0 showing 0.
